// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// parity rule used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 11;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: serial line in, recovered byte and status pulses out.
interface uart_rx_frame_if;

  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin (resets to the idle-high
// level) plus a falling-edge detect on the synchronized line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Metastability chain and one-cycle history of the synchronized line
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rx_sync = sync_r;
  assign fall    = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, 8 data bits MSB first, even parity, stop.
// Samples at bit centres and reports bytes with one-cycle status pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_frame_if.master  bus
);

  localparam int                TICK_W    = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 fall_s;

  rx_state_t            state_r;
  rx_state_t            state_next_s;
  logic [TICK_W-1:0]    tick_r;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;

  logic                 shift_en_s;
  logic                 bit_clr_s;
  logic                 par_latch_s;
  logic                 valid_set_s;
  logic                 ferr_set_s;

  logic [DATA_BITS-1:0] data_out_r;
  logic                 data_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 busy_r;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (bus.rx),
    .rx_sync (rx_s),
    .fall    (fall_s)
  );

  // Next-state and per-cycle action decode
  always_comb begin
    state_next_s = state_r;
    shift_en_s   = 1'b0;
    bit_clr_s    = 1'b0;
    par_latch_s  = 1'b0;
    valid_set_s  = 1'b0;
    ferr_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        // A start bit that is high again by mid-bit was a glitch
        if (tick_r == TICK_MID) begin
          if (rx_s == START_BIT) begin
            state_next_s = DATA;
            bit_clr_s    = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (tick_r == TICK_LAST) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == BIT_LAST) begin
            state_next_s = PARITY;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (tick_r == TICK_LAST) begin
          par_latch_s  = 1'b1;
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (tick_r == TICK_LAST) begin
          if (rx_s == STOP_BIT) begin
            valid_set_s  = 1'b1;
            state_next_s = IDLE;
          end else begin
            ferr_set_s   = 1'b1;
            state_next_s = BREAK;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      BREAK: begin
        // Hold here while the line stays low so it cannot look like a start
        if (rx_s == STOP_BIT) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BREAK;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and bit-period tick counter, cleared on every state entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      tick_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if ((state_next_s != state_r) || (tick_r == TICK_LAST)) begin
        tick_r <= '0;
      end else begin
        tick_r <= tick_r + TICK_W'(1);
      end
    end
  end

  // Data shift register, bit counter and parity capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= '0;
      par_bit_r <= 1'b0;
    end else begin
      if (bit_clr_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (shift_en_s) begin
        shift_r <= {shift_r[DATA_BITS-2:0], rx_s};
      end else begin
        shift_r <= shift_r;
      end
      if (par_latch_s) begin
        par_bit_r <= rx_s;
      end else begin
        par_bit_r <= par_bit_r;
      end
    end
  end

  // Registered outputs: byte, status pulses and busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (valid_set_s) begin
        data_out_r <= shift_r;
      end else begin
        data_out_r <= data_out_r;
      end
      data_valid_r <= valid_set_s;
      parity_err_r <= valid_set_s & (par_bit_r ^ even_parity(shift_r));
      frame_err_r  <= ferr_set_s;
      busy_r       <= (state_next_s != IDLE);
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus random frames,
// compared against a frame-level reference model of expected output events.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int CPB = 8;
  localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_if bus ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         excl_bad = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every output pulse with the edge count at which it appeared
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1 || bus.frame_err === 1'b1)
      obs_q.push_back('{cyc, bus.frame_err, bus.data_out, bus.parity_err});
    if ((bus.data_valid === 1'b1 && bus.frame_err === 1'b1) ||
        (bus.parity_err === 1'b1 && bus.data_valid !== 1'b1))
      excl_bad++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx = fr[FRAME_BITS-1-i];
      tick(CPB);
    end
  endtask

  // Reference: a good stop bit yields a data_valid LAT clocks after the start
  // edge; a bad one yields frame_err at the same point with data_out unchanged.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.ferr = ~stp;
    e.data = stp ? d : last_good;
    e.perr = stp & (par != (^d));
    exp_q.push_back(e);
    if (stp) last_good = d;
    drive_bits({1'b0, d, par, stp}, FRAME_BITS);
  endtask

  task automatic check_events(input string tag);
    while (exp_q.size() > 0) begin
      ev_t e;
      ev_t o;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, " missing_event_at"}, 32'd0, e.cyc);
      end else begin
        o = obs_q.pop_front();
        chk({tag, " cycle"}, o.cyc, e.cyc);
        chk({tag, " frame_err"}, {31'd0, o.ferr}, {31'd0, e.ferr});
        chk({tag, " data_out"}, {24'd0, o.data}, {24'd0, e.data});
        chk({tag, " parity_err"}, {31'd0, o.perr}, {31'd0, e.perr});
      end
    end
    chk({tag, " extra_events"}, obs_q.size(), 32'd0);
    obs_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " data_out"}, {24'd0, bus.data_out}, 32'd0);
    chk({tag, " data_valid"}, {31'd0, bus.data_valid}, 32'd0);
    chk({tag, " parity_err"}, {31'd0, bus.parity_err}, 32'd0);
    chk({tag, " frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    rst       = 1'b0;
    bus.rx    = 1'b1;
    last_good = 8'h00;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(4);

    // Clean 0xA5, correct even parity (0)
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(4);
    check_events("a5");
    chk("a5 hold", {24'd0, bus.data_out}, 32'h000000A5);
    chk("a5 idle busy", {31'd0, bus.busy}, 32'd0);

    // 0x3C with parity forced to 1 (correct would be 0)
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(4);
    check_events("3c_par");

    // 0xFF with stop bit 0, line kept low, then released
    send_frame(8'hFF, 1'b0, 1'b0);
    tick(40);
    chk("break busy", {31'd0, bus.busy}, 32'd1);
    check_events("ff_ferr");
    chk("ff data_out kept", {24'd0, bus.data_out}, 32'h0000003C);
    bus.rx = 1'b1;
    tick(2);
    chk("break release busy", {31'd0, bus.busy}, 32'd1);
    tick(2);
    chk("break idle busy", {31'd0, bus.busy}, 32'd0);
    tick(4);

    // Two-clock low glitch on an idle line
    bus.rx = 1'b0;
    tick(2);
    bus.rx = 1'b1;
    tick(2);
    chk("glitch busy", {31'd0, bus.busy}, 32'd1);
    tick(CPB / 2 + 3 - 4);
    chk("glitch idle", {31'd0, bus.busy}, 32'd0);
    tick(10);
    check_events("glitch");

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    tick(4);
    check_events("b2b");

    // Reset while receiving the data bits of 0x55, then a clean 0x12
    drive_bits({1'b0, 8'h55, 1'b0, 1'b1}, 4);
    rst    = 1'b0;
    bus.rx = 1'b1;
    tick(2);
    chk_all_zero("midreset");
    last_good = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(10);
    check_events("rst_abort");
    send_frame(8'h12, 1'b0, 1'b1);
    tick(4);
    check_events("12");

    // Random frames with random parity/stop faults and random gaps
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      if (!s) begin
        bus.rx = 1'b1;
        tick($urandom_range(4, 12));
      end else begin
        tick($urandom_range(0, 6));
      end
    end
    tick(4);
    check_events("rand");
    chk("rand hold", {24'd0, bus.data_out}, {24'd0, last_good});

    chk("exclusivity", excl_bad, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receiver that consumes the line driven by the team's UART transmitter and recovers bytes from it.
- Frame: start bit (0), 8 data bits MSB first, even-parity bit (XOR of the 8 data bits), stop bit (1). 11 bits total; line idles high.
- Bit period is a fixed number of clk cycles. No fractional baud.
- Sits between the external RX pin and the byte-consumer logic. Outputs one-cycle valid pulses plus error flags.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal values are ≥4 and even.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last received byte; holds until the next valid frame.
- data_valid  output  1  one-cycle pulse: data_out updated, frame stop bit OK.
- parity_err  output  1  one-cycle pulse, coincident with data_valid, when received parity ≠ ^data_out.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0; no data_valid for that frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst==0 at posedge):
  - data_out=0; data_valid, parity_err, frame_err, busy = 0.
  - Synchronizer flops = 1. State = IDLE. Bit counter and tick counter = 0.
  - Reset mid-frame abandons the frame silently.
- Input path:
  - rx passes through a 2-flop synchronizer; call the output rx_s.
  - The falling-edge detect compares rx_s with its previous value.
  - Decoding sees the line 2 clk after the pin.
- Tick counter: counts 0..CLKS_PER_BIT-1 and wraps. It is cleared on every state entry.
- State machine:
  - IDLE: on a falling edge of rx_s -> START, tick cleared.
  - START: at tick==CLKS_PER_BIT/2-1 (mid-bit), sample rx_s.
    - 0 -> DATA, tick cleared, bit_cnt=0.
    - 1 -> IDLE (glitch rejected, no flags raised).
  - DATA: each time tick==CLKS_PER_BIT-1, sample rx_s and shift it into shift_reg.
    - Shift is left, new bit enters at LSB, so the first received bit ends up as bit 7.
    - bit_cnt increments on each sample. After the 8th sample -> PARITY.
  - PARITY: at tick==CLKS_PER_BIT-1, latch the parity bit -> STOP.
  - STOP: at tick==CLKS_PER_BIT-1, sample rx_s.
    - 1: next cycle data_out<=shift_reg, data_valid=1, parity_err=(par_bit ^ ^shift_reg); -> IDLE.
    - 0: next cycle frame_err=1, data_out unchanged; -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. This prevents a held-low line from re-triggering START.
- Latency: data_valid rises 1 clk after the stop-bit mid-sample.
  - Pin start edge to data_valid = 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 clk.
  - With default 8 this is 87 clk.
- Sample points: all samples after START fall at bit centres, offset half a bit from the start edge.
- Back-to-back frames: IDLE is re-entered the cycle after the STOP sample. A start edge arriving during the second half of the stop bit is detected normally.
- No flow control: if the consumer ignores data_valid, data_out is simply overwritten by the next frame.
- Output exclusivity: data_valid and frame_err are never high together. parity_err is never high without data_valid.

Decomposition:
- Shared package uart_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, FRAME_BITS=11.
  - The parity-function definition, reused by the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset-to-1, plus falling-edge detect output.
- Tick width is $clog2(CLKS_PER_BIT); bit_cnt is 3 bits.

Test Plan:
- Clean frame 0xA5 (line 0,10100101,0,1) at 8 clk/bit -> exactly one data_valid, data_out=0xA5, parity_err=0, 87 clk after start edge.
- Frame 0x3C with parity bit forced 1 -> data_valid=1, data_out=0x3C, parity_err=1 in the same cycle.
- Frame 0xFF with stop bit 0, line held low 40 clk, then high -> frame_err pulse, no data_valid, data_out keeps its previous value, busy stays 1 until the line goes high, then IDLE.
- Low glitch of 2 clk on an idle line -> START aborts at the mid-sample, no pulses, busy back to 0 within CLKS_PER_BIT/2+3 clk.
- Back-to-back 0x01 then 0x80 with no idle gap -> two data_valid pulses 88 clk apart, values 0x01 then 0x80, no errors.
- rst driven low during DATA of 0x55, released, then a clean 0x12 -> no pulse for 0x55; 0x12 received correctly; all outputs 0 during reset.
